medidor_pulso: RTL and testbench
================================

MEDIDOR_PULSO -- requirements
Module: medidor_pulso

Interface
REQ-001 Parameter BIT_fin, default 26, width of the cycle counter and of width.
REQ-002 Parameter MIN_W, default 26'd500000 (10 ms at 50 MHz), shortest high time accepted as a valid pulse.
REQ-003 Parameter LONG_W, default 26'd50000000 (1 s), shortest high time classed as long; MIN_W <= LONG_W <= 2^BIT_fin-1 SHALL hold.
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sig  input  1  level to be measured (button, or a timer's hold output).
REQ-007 busy  output  1  high while a high level is being timed.
REQ-008 short_p  output  1  one-cycle pulse: accepted pulse with MIN_W <= width < LONG_W.
REQ-009 long_p  output  1  one-cycle pulse: accepted pulse with width >= LONG_W.
REQ-010 valid  output  1  one-cycle pulse, coincident with short_p or long_p.
REQ-011 width  output  BIT_fin  high time in clk cycles of the last accepted pulse.

Function
REQ-012 Internal level sig_s SHALL be sig, after the optional synchronizer (REQ-024/025).
REQ-013 FSM states SHALL be WAIT_LOW, IDLE, COUNT.
REQ-014 WAIT_LOW: go to IDLE on the first cycle sig_s = 0; otherwise stay; a level already high out of reset SHALL never be measured.
REQ-015 IDLE: sig_s = 1 -> COUNT with cnt <= 1; otherwise stay.
REQ-016 COUNT: sig_s = 1 -> cnt <= cnt+1, saturating at 2^BIT_fin-1 (no wrap).
REQ-017 COUNT: sig_s = 0 -> IDLE on the same edge; width equals the number of cycles sig_s was sampled high.
REQ-018 On that edge: cnt < MIN_W -> glitch, no output pulse, width unchanged.
REQ-019 On that edge: MIN_W <= cnt < LONG_W -> short_p = 1 and valid = 1 for exactly one cycle; width <= cnt.
REQ-020 On that edge: cnt >= LONG_W -> long_p = 1 and valid = 1 for exactly one cycle; width <= cnt (saturated value if saturated).
REQ-021 short_p and long_p SHALL never be high together; all outputs registered.
REQ-022 busy SHALL be 1 exactly while in COUNT; a new rising level on the cycle after a report SHALL start a new measurement (back-to-back allowed).

Reset
REQ-023 rst_n low SHALL immediately force state WAIT_LOW, cnt 0, width 0, busy/short_p/long_p/valid 0, synchronizer flops 0; reset mid-COUNT discards the measurement.

Configuration
REQ-024 With MEDIDOR_PULSO_SYNC_EN defined: sig SHALL pass a 2-flop synchronizer, adding 2 cycles latency to every transition; width is unaffected.
REQ-025 Without MEDIDOR_PULSO_SYNC_EN: sig_s = sig directly, for sources already synchronous to clk; zero added latency.

Structure
REQ-026 Package medidor_pulso_pkg SHALL hold the state encoding (WAIT_LOW=0, IDLE=1, COUNT=2) and the default MIN_W, LONG_W, BIT_fin values.
REQ-027 Synchronizer SHALL be sub-module sincronizador (2 flops, async active-low reset, reset value 0), instantiated only under MEDIDOR_PULSO_SYNC_EN.

Verification (BIT_fin=8, MIN_W=4, LONG_W=10, macro off unless stated)
REQ-028 sig=1 through reset release, held 20 cycles, then 0 -> no valid; next 6-cycle pulse -> short_p, width=6.
REQ-029 3-cycle pulse -> no short_p/long_p/valid, busy high 3 cycles; 4-cycle pulse -> short_p, width=4.
REQ-030 9-cycle pulse -> short_p, width=9; 10-cycle pulse -> long_p, width=10; valid coincident each time.
REQ-031 BIT_fin=4, MIN_W=4, LONG_W=10, sig high 40 cycles -> long_p, width=15 (saturated).
REQ-032 rst_n low at cycle 5 of a 12-cycle pulse -> all outputs 0 at once, no report; measurement resumes only after sig returns low.
REQ-033 Macro on, 6-cycle pulse -> busy rises 2 cycles after sig, short_p, width=6; two 6-cycle pulses separated by 1 low cycle -> two short_p reports.

Source files
------------

// File: rtl/medidor_pulso_pkg.sv
// Shared state encoding and default timing thresholds for the pulse-width meter.
package medidor_pulso_pkg;

    localparam int unsigned BIT_FIN_DEF = 26;
    localparam logic [BIT_FIN_DEF-1:0] MIN_W_DEF  = 26'd500000;
    localparam logic [BIT_FIN_DEF-1:0] LONG_W_DEF = 26'd50000000;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        COUNT    = 2'd2
    } state_t;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for an asynchronous level; clears to 0 on reset.
module sincronizador (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/medidor_pulso.sv
// Measures high time of sig in clk cycles and classifies it as glitch, short or long.
// Define MEDIDOR_PULSO_SYNC_EN to insert a 2-flop synchronizer on sig.
module medidor_pulso
    import medidor_pulso_pkg::*;
#(
    parameter int unsigned           BIT_fin = BIT_FIN_DEF,
    parameter logic [BIT_fin-1:0]    MIN_W   = BIT_fin'(MIN_W_DEF),
    parameter logic [BIT_fin-1:0]    LONG_W  = BIT_fin'(LONG_W_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sig,
    output logic               busy,
    output logic               short_p,
    output logic               long_p,
    output logic               valid,
    output logic [BIT_fin-1:0] width
);

    localparam logic [BIT_fin-1:0] CNT_MAX = '1;

    logic sig_s;

`ifdef MEDIDOR_PULSO_SYNC_EN
    sincronizador u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig),
        .q     (sig_s)
    );
`else
    assign sig_s = sig;
`endif

    state_t             state, state_nxt;
    logic [BIT_fin-1:0] cnt, cnt_nxt;
    logic [BIT_fin-1:0] width_nxt;
    logic               busy_nxt, short_nxt, long_nxt, valid_nxt;

    // State, counter and all outputs registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_LOW;
            cnt     <= '0;
            width   <= '0;
            busy    <= 1'b0;
            short_p <= 1'b0;
            long_p  <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            width   <= width_nxt;
            busy    <= busy_nxt;
            short_p <= short_nxt;
            long_p  <= long_nxt;
            valid   <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        width_nxt = width;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        valid_nxt = 1'b0;

        case (state)
            WAIT_LOW: begin
                if (!sig_s) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (sig_s) begin
                    state_nxt = COUNT;
                    cnt_nxt   = BIT_fin'(1);
                end
            end
            COUNT: begin
                if (sig_s) begin
                    // Saturate rather than wrap so over-long pulses still read as long
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + BIT_fin'(1);
                    end
                end else begin
                    state_nxt = IDLE;
                    if (cnt >= LONG_W) begin
                        long_nxt  = 1'b1;
                        valid_nxt = 1'b1;
                        width_nxt = cnt;
                    end else if (cnt >= MIN_W) begin
                        short_nxt = 1'b1;
                        valid_nxt = 1'b1;
                        width_nxt = cnt;
                    end
                end
            end
            default: begin
                state_nxt = WAIT_LOW;
            end
        endcase

        busy_nxt = (state_nxt == COUNT);
    end

endmodule

// File: tb/tb_medidor_pulso.sv
// Directed bench for medidor_pulso: thresholds, saturation, reset abort, back-to-back pulses.
module tb_medidor_pulso;

`ifdef MEDIDOR_PULSO_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       sig_a, sig_b;
    logic       busy, short_p, long_p, valid;
    logic [7:0] width;
    logic       busy_b, short_b, long_b, valid_b;
    logic [3:0] width_b;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0, valid_cnt = 0, short_cnt = 0, long_cnt = 0, overlap_cnt = 0;

    medidor_pulso #(.BIT_fin(8), .MIN_W(8'd4), .LONG_W(8'd10)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig     (sig_a),
        .busy    (busy),
        .short_p (short_p),
        .long_p  (long_p),
        .valid   (valid),
        .width   (width)
    );

    medidor_pulso #(.BIT_fin(4), .MIN_W(4'd4), .LONG_W(4'd10)) u_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig     (sig_b),
        .busy    (busy_b),
        .short_p (short_b),
        .long_p  (long_b),
        .valid   (valid_b),
        .width   (width_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        busy_cnt    <= busy_cnt + int'(busy);
        valid_cnt   <= valid_cnt + int'(valid);
        short_cnt   <= short_cnt + int'(short_p);
        long_cnt    <= long_cnt + int'(long_p);
        overlap_cnt <= overlap_cnt + int'(short_p & long_p) + int'(short_b & long_b);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 glitch, 1 short, 2 long
    task automatic pulse(input string tag, input int n, input int kind, input logic [7:0] w);
        int b0, v0;
        logic [7:0] wprev;
        b0 = busy_cnt;
        v0 = valid_cnt;
        wprev = width;
        sig_a = 1'b1;
        repeat (LAT) @(posedge clk);
        #1 check({tag, "_busy_pre"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1 check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        repeat (n - LAT - 1) @(posedge clk);
        #1 sig_a = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 32'(valid), 32'(kind != 0));
        check({tag, "_short"}, 32'(short_p), 32'(kind == 1));
        check({tag, "_long"}, 32'(long_p), 32'(kind == 2));
        check({tag, "_width"}, 32'(width), (kind != 0) ? 32'(w) : 32'(wprev));
        @(posedge clk);
        #1 check({tag, "_valid_drop"}, 32'(valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'(n));
        check({tag, "_reports"}, 32'(valid_cnt - v0), 32'(kind != 0));
    endtask

    initial begin
        int v0, s0;
        rst_n = 1'b0;
        sig_a = 1'b1;
        sig_b = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_short", 32'(short_p), 32'd0);
        check("rst_long", 32'(long_p), 32'd0);
        check("rst_width", 32'(width), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Level high out of reset must be ignored
        v0 = valid_cnt;
        repeat (20) @(posedge clk);
        #1 sig_a = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("held_high_reports", 32'(valid_cnt - v0), 32'd0);
        check("held_high_busy", 32'(busy_cnt), 32'd0);

        pulse("p6", 6, 1, 8'd6);
        pulse("p3", 3, 0, 8'd0);
        pulse("p4", 4, 1, 8'd4);
        pulse("p9", 9, 1, 8'd9);
        pulse("p10", 10, 2, 8'd10);
        pulse("p12", 12, 2, 8'd12);

        // Saturation on the 4-bit instance
        sig_b = 1'b1;
        repeat (40) @(posedge clk);
        #1 sig_b = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        check("sat_valid", 32'(valid_b), 32'd1);
        check("sat_long", 32'(long_b), 32'd1);
        check("sat_short", 32'(short_b), 32'd0);
        check("sat_width", 32'(width_b), 32'd15);
        @(posedge clk);
        #1;

        // Reset in the middle of a 12-cycle pulse
        v0 = valid_cnt;
        sig_a = 1'b1;
        repeat (5 + LAT) @(posedge clk);
        #1 check("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_width", 32'(width), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("mid_no_restart", 32'(busy), 32'd0);
        sig_a = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("mid_reports", 32'(valid_cnt - v0), 32'd0);
        check("mid_width", 32'(width), 32'd0);

        pulse("after_rst", 6, 1, 8'd6);

        // Two 6-cycle pulses separated by a single low cycle
        s0 = short_cnt;
        sig_a = 1'b1;
        repeat (6) @(posedge clk);
        #1 sig_a = 1'b0;
        @(posedge clk);
        #1 sig_a = 1'b1;
        repeat (6) @(posedge clk);
        #1 sig_a = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        check("b2b_short", 32'(short_p), 32'd1);
        check("b2b_width", 32'(width), 32'd6);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_reports", 32'(short_cnt - s0), 32'd2);
        check("b2b_busy_end", 32'(busy), 32'd0);
        check("never_both", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
